// File: rtl/instr_encoder.sv
// instr_encoder: encodes abstract RV64IM instruction requests into 32-bit
// instruction words and queues them in a small FIFO.
// Illegal requests are queued as a zero word with out_illegal set, and they
// bump a saturating counter.
//
// Ports:
//   clk, resetn                   clock and async active-low reset
//   in_valid / in_ready           request handshake (in_ready = FIFO not full)
//   in_cls, in_fn                 instruction class and sub-function
//   in_rd, in_rs1, in_rs2         register indices (in_rs1 = zimm for CSR*I)
//   in_imm                        signed immediate / CSR address / upper imm
//   out_valid / out_ready         result handshake (out_valid = FIFO not empty)
//   out_instr, out_illegal        FIFO head contents
//   illegal_cnt                   saturating count of accepted illegal requests
module instr_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_cls,
  input  logic [3:0]      in_fn,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [31:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_illegal,
  output logic [CNTW-1:0] illegal_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = PW + 1;

  // instruction classes
  localparam logic [3:0] CLS_ALUI   = 4'd0;
  localparam logic [3:0] CLS_ALU    = 4'd1;
  localparam logic [3:0] CLS_ALUIW  = 4'd2;
  localparam logic [3:0] CLS_ALUW   = 4'd3;
  localparam logic [3:0] CLS_LUI    = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_BRANCH = 4'd6;
  localparam logic [3:0] CLS_LOAD   = 4'd7;
  localparam logic [3:0] CLS_STORE  = 4'd8;
  localparam logic [3:0] CLS_AUIPC  = 4'd9;
  localparam logic [3:0] CLS_JALR   = 4'd10;
  localparam logic [3:0] CLS_SYSTEM = 4'd11;

  // ALU sub-functions
  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_SLL  = 4'd2;
  localparam logic [3:0] FN_SLT  = 4'd3;
  localparam logic [3:0] FN_SLTU = 4'd4;
  localparam logic [3:0] FN_XOR  = 4'd5;
  localparam logic [3:0] FN_SRL  = 4'd6;
  localparam logic [3:0] FN_SRA  = 4'd7;
  localparam logic [3:0] FN_OR   = 4'd8;
  localparam logic [3:0] FN_AND  = 4'd9;
  localparam logic [3:0] FN_MUL  = 4'd10;
  localparam logic [3:0] FN_DIV  = 4'd11;
  localparam logic [3:0] FN_DIVU = 4'd12;
  localparam logic [3:0] FN_REM  = 4'd13;
  localparam logic [3:0] FN_REMU = 4'd14;

  // opcodes
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUIW  = 7'b0011011;
  localparam logic [6:0] OP_ALUW   = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } entry_t;

  // ---------------------------------------------------------------------
  // ALU sub-function -> funct3 / funct7
  // ---------------------------------------------------------------------
  logic [2:0] alu_f3;
  logic [6:0] alu_f7;
  logic       alu_shift;
  logic       alu_sra;
  logic       alu_m;

  always_comb begin
    alu_f3 = 3'b000;
    alu_f7 = 7'b0000000;
    unique case (in_fn)
      FN_ADD:  alu_f3 = 3'b000;
      FN_SUB:  begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
      FN_SLL:  alu_f3 = 3'b001;
      FN_SLT:  alu_f3 = 3'b010;
      FN_SLTU: alu_f3 = 3'b011;
      FN_XOR:  alu_f3 = 3'b100;
      FN_SRL:  alu_f3 = 3'b101;
      FN_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; end
      FN_OR:   alu_f3 = 3'b110;
      FN_AND:  alu_f3 = 3'b111;
      FN_MUL:  begin alu_f3 = 3'b000; alu_f7 = 7'b0000001; end
      FN_DIV:  begin alu_f3 = 3'b100; alu_f7 = 7'b0000001; end
      FN_DIVU: begin alu_f3 = 3'b101; alu_f7 = 7'b0000001; end
      FN_REM:  begin alu_f3 = 3'b110; alu_f7 = 7'b0000001; end
      FN_REMU: begin alu_f3 = 3'b111; alu_f7 = 7'b0000001; end
      default: ;
    endcase
  end

  assign alu_shift = (in_fn == FN_SLL) || (in_fn == FN_SRL) || (in_fn == FN_SRA);
  assign alu_sra   = (in_fn == FN_SRA);
  assign alu_m     = (in_fn >= FN_MUL) && (in_fn <= FN_REMU);

  // Immediate range checks: sign-extension bits above the field must agree.
  logic imm_i_ok;
  logic imm_b_ok;
  logic imm_j_ok;

  assign imm_i_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign imm_b_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
  assign imm_j_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

  // ---------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------
  logic [31:0] enc_instr;
  logic        enc_ill;

  always_comb begin
    enc_instr = 32'h0000_0000;
    enc_ill   = 1'b0;
    unique case (in_cls)
      CLS_ALUI: begin
        if ((in_fn == FN_SUB) || alu_m || (in_fn > FN_REMU)) begin
          enc_ill = 1'b1;
        end else if (alu_shift) begin
          enc_ill   = |in_imm[31:6];
          enc_instr = {1'b0, alu_sra, 4'b0000, in_imm[5:0], in_rs1, alu_f3, in_rd, OP_ALUI};
        end else begin
          enc_ill   = !imm_i_ok;
          enc_instr = {in_imm[11:0], in_rs1, alu_f3, in_rd, OP_ALUI};
        end
      end
      CLS_ALU: begin
        enc_ill   = (in_fn > FN_REMU);
        enc_instr = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, OP_ALU};
      end
      CLS_ALUIW: begin
        // only ADDIW and the three word shifts exist
        if (alu_shift) begin
          enc_ill   = |in_imm[31:5];
          enc_instr = {1'b0, alu_sra, 5'b00000, in_imm[4:0], in_rs1, alu_f3, in_rd, OP_ALUIW};
        end else if (in_fn == FN_ADD) begin
          enc_ill   = !imm_i_ok;
          enc_instr = {in_imm[11:0], in_rs1, alu_f3, in_rd, OP_ALUIW};
        end else begin
          enc_ill = 1'b1;
        end
      end
      CLS_ALUW: begin
        enc_ill   = !((in_fn == FN_ADD) || (in_fn == FN_SUB) || alu_shift || alu_m);
        enc_instr = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, OP_ALUW};
      end
      CLS_LUI: begin
        enc_ill   = |in_imm[11:0];
        enc_instr = {in_imm[31:12], in_rd, OP_LUI};
      end
      CLS_AUIPC: begin
        enc_ill   = |in_imm[11:0];
        enc_instr = {in_imm[31:12], in_rd, OP_AUIPC};
      end
      CLS_JAL: begin
        enc_ill   = !imm_j_ok;
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      end
      CLS_BRANCH: begin
        enc_ill   = !imm_b_ok || (in_fn[2:0] == 3'b010) || (in_fn[2:0] == 3'b011);
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_fn[2:0],
                     in_imm[4:1], in_imm[11], OP_BRANCH};
      end
      CLS_LOAD: begin
        enc_ill   = !imm_i_ok || (in_fn[2:0] == 3'b111);
        enc_instr = {in_imm[11:0], in_rs1, in_fn[2:0], in_rd, OP_LOAD};
      end
      CLS_STORE: begin
        enc_ill   = !imm_i_ok || in_fn[2];
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_fn[2:0], in_imm[4:0], OP_STORE};
      end
      CLS_JALR: begin
        enc_ill   = !imm_i_ok;
        enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      end
      CLS_SYSTEM: begin
        // CSR address is an unsigned 12-bit field; rd forced to x0 for privileged ops
        unique case (in_fn)
          4'd0:    enc_instr = {12'h000, 5'd0, 3'b000, 5'd0, OP_SYSTEM};
          4'd1:    enc_instr = {12'h302, 5'd0, 3'b000, 5'd0, OP_SYSTEM};
          4'd2:    enc_instr = {7'b0001001, in_rs2, in_rs1, 3'b000, 5'd0, OP_SYSTEM};
          4'd3:    enc_instr = {in_imm[11:0], in_rs1, 3'b001, in_rd, OP_SYSTEM};
          4'd4:    enc_instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_SYSTEM};
          4'd5:    enc_instr = {in_imm[11:0], in_rs1, 3'b011, in_rd, OP_SYSTEM};
          4'd6:    enc_instr = {in_imm[11:0], in_rs1, 3'b101, in_rd, OP_SYSTEM};
          4'd7:    enc_instr = {in_imm[11:0], in_rs1, 3'b110, in_rd, OP_SYSTEM};
          4'd8:    enc_instr = {in_imm[11:0], in_rs1, 3'b111, in_rd, OP_SYSTEM};
          default: enc_ill = 1'b1;
        endcase
      end
      default: enc_ill = 1'b1;
    endcase
    if (enc_ill) begin
      enc_instr = 32'h0000_0000;
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO: extra pointer bit separates full from empty
  // ---------------------------------------------------------------------
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_d;
  logic          push;
  logic          pop;
  logic          full_d;
  logic          empty_d;
  logic          rdy_q;
  logic          vld_q;

  assign push = in_valid && rdy_q;
  assign pop  = vld_q && out_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_d = pop  ? rd_ptr + AW'(1) : rd_ptr;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]) && (wr_ptr_d[PW] != rd_ptr_d[PW]);
  end

  // Pointers and registered handshake flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      rdy_q  <= !full_d;
      vld_q  <= !empty_d;
    end
  end

  // Storage, cleared on reset so the head reads as zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[PW-1:0]] <= '{illegal: enc_ill, instr: enc_instr};
    end
  end

  // Saturating illegal-request counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      illegal_cnt <= '0;
    end else if (push && enc_ill && (illegal_cnt != {CNTW{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNTW'(1);
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = vld_q;
  assign out_instr   = mem[rd_ptr[PW-1:0]].instr;
  assign out_illegal = mem[rd_ptr[PW-1:0]].illegal;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encoding table plus backpressure,
// mid-operation reset and counter saturation sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cls;
  logic [3:0]  in_fn;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  instr_encoder #(.DEPTH(2), .CNTW(16)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_fn(in_fn), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [3:0]  fn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_ill;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic [3:0] cls, input logic [3:0] fn,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm, input logic [31:0] ei, input logic il);
    vec_t v;
    v.name = name; v.cls = cls; v.fn = fn; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_instr = ei; v.exp_ill = il;
    vecs.push_back(v);
  endtask

  task automatic set_req(input logic [3:0] cls, input logic [3:0] fn, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_cls = cls; in_fn = fn; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  initial begin
    int          exp_cnt;
    int          n_acc;
    int          guard;

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rel_in_ready_first_edge", 32'(in_ready), 32'd1);

    // ---------------- encoding table ----------------
    add("add",        4'd1,  4'd0,  5'd1,  5'd2,  5'd3,  32'd0,          32'h003100B3, 1'b0);
    add("sub",        4'd1,  4'd1,  5'd5,  5'd6,  5'd7,  32'd0,          32'h407302B3, 1'b0);
    add("mul",        4'd1,  4'd10, 5'd10, 5'd11, 5'd12, 32'd0,          32'h02C58533, 1'b0);
    add("alu_fn15",   4'd1,  4'd15, 5'd1,  5'd2,  5'd3,  32'd0,          32'h0,        1'b1);
    add("sraiw31",    4'd2,  4'd7,  5'd5,  5'd6,  5'd0,  32'd31,         32'h41F3529B, 1'b0);
    add("sraiw32",    4'd2,  4'd7,  5'd5,  5'd6,  5'd0,  32'd32,         32'h0,        1'b1);
    add("slliw31",    4'd2,  4'd2,  5'd1,  5'd2,  5'd0,  32'd31,         32'h01F1109B, 1'b0);
    add("addiw_m1",   4'd2,  4'd0,  5'd1,  5'd2,  5'd0,  32'hFFFFFFFF,   32'hFFF1009B, 1'b0);
    add("aluiw_xor",  4'd2,  4'd5,  5'd1,  5'd2,  5'd0,  32'd1,          32'h0,        1'b1);
    add("beq_m4",     4'd6,  4'd0,  5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,   32'hFE208EE3, 1'b0);
    add("br_odd",     4'd6,  4'd0,  5'd0,  5'd1,  5'd2,  32'd3,          32'h0,        1'b1);
    add("bne_m4096",  4'd6,  4'd1,  5'd0,  5'd1,  5'd2,  32'hFFFFF000,   32'h80209063, 1'b0);
    add("beq_4094",   4'd6,  4'd0,  5'd0,  5'd1,  5'd2,  32'd4094,       32'h7E208FE3, 1'b0);
    add("br_4096",    4'd6,  4'd0,  5'd0,  5'd1,  5'd2,  32'd4096,       32'h0,        1'b1);
    add("br_f3_010",  4'd6,  4'd2,  5'd0,  5'd1,  5'd2,  32'd8,          32'h0,        1'b1);
    add("addi_m1",    4'd0,  4'd0,  5'd1,  5'd0,  5'd0,  32'hFFFFFFFF,   32'hFFF00093, 1'b0);
    add("addi_m2048", 4'd0,  4'd0,  5'd1,  5'd0,  5'd0,  32'hFFFFF800,   32'h80000093, 1'b0);
    add("addi_2048",  4'd0,  4'd0,  5'd1,  5'd0,  5'd0,  32'd2048,       32'h0,        1'b1);
    add("srai63",     4'd0,  4'd7,  5'd1,  5'd2,  5'd0,  32'd63,         32'h43F15093, 1'b0);
    add("slli64",     4'd0,  4'd2,  5'd1,  5'd2,  5'd0,  32'd64,         32'h0,        1'b1);
    add("alui_sub",   4'd0,  4'd1,  5'd1,  5'd2,  5'd0,  32'd1,          32'h0,        1'b1);
    add("alui_mul",   4'd0,  4'd10, 5'd1,  5'd2,  5'd0,  32'd1,          32'h0,        1'b1);
    add("divw",       4'd3,  4'd11, 5'd1,  5'd2,  5'd3,  32'd0,          32'h023140BB, 1'b0);
    add("aluw_slt",   4'd3,  4'd3,  5'd1,  5'd2,  5'd3,  32'd0,          32'h0,        1'b1);
    add("lui",        4'd4,  4'd0,  5'd1,  5'd0,  5'd0,  32'h12345000,   32'h123450B7, 1'b0);
    add("lui_low",    4'd4,  4'd0,  5'd1,  5'd0,  5'd0,  32'h12345001,   32'h0,        1'b1);
    add("auipc",      4'd9,  4'd0,  5'd3,  5'd0,  5'd0,  32'h00001000,   32'h00001197, 1'b0);
    add("jal_2048",   4'd5,  4'd0,  5'd1,  5'd0,  5'd0,  32'd2048,       32'h001000EF, 1'b0);
    add("jal_min",    4'd5,  4'd0,  5'd1,  5'd0,  5'd0,  32'hFFF00000,   32'h800000EF, 1'b0);
    add("jal_2p20",   4'd5,  4'd0,  5'd1,  5'd0,  5'd0,  32'h00100000,   32'h0,        1'b1);
    add("jal_odd",    4'd5,  4'd0,  5'd1,  5'd0,  5'd0,  32'd5,          32'h0,        1'b1);
    add("jalr",       4'd10, 4'd0,  5'd1,  5'd5,  5'd0,  32'd0,          32'h000280E7, 1'b0);
    add("ld",         4'd7,  4'd3,  5'd5,  5'd10, 5'd0,  32'd8,          32'h00853283, 1'b0);
    add("ld_f3_111",  4'd7,  4'd7,  5'd5,  5'd10, 5'd0,  32'd8,          32'h0,        1'b1);
    add("sd",         4'd8,  4'd3,  5'd0,  5'd10, 5'd5,  32'd16,         32'h00553823, 1'b0);
    add("st_f3_100",  4'd8,  4'd4,  5'd0,  5'd10, 5'd5,  32'd16,         32'h0,        1'b1);
    add("ecall_rd7",  4'd11, 4'd0,  5'd7,  5'd3,  5'd4,  32'd0,          32'h00000073, 1'b0);
    add("mret",       4'd11, 4'd1,  5'd3,  5'd4,  5'd0,  32'd0,          32'h30200073, 1'b0);
    add("sfence",     4'd11, 4'd2,  5'd9,  5'd1,  5'd2,  32'd0,          32'h12208073, 1'b0);
    add("csrrw",      4'd11, 4'd3,  5'd1,  5'd2,  5'd0,  32'h300,        32'h300110F3, 1'b0);
    add("csrrwi",     4'd11, 4'd6,  5'd1,  5'd5,  5'd0,  32'h300,        32'h3002D0F3, 1'b0);
    add("sys_fn9",    4'd11, 4'd9,  5'd1,  5'd2,  5'd0,  32'd0,          32'h0,        1'b1);
    add("cls12",      4'd12, 4'd0,  5'd1,  5'd2,  5'd3,  32'd0,          32'h0,        1'b1);

    exp_cnt = 0;
    foreach (vecs[i]) begin
      set_req(vecs[i].cls, vecs[i].fn, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      in_valid = 1'b1; out_ready = 1'b0;
      chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      if (vecs[i].exp_ill) exp_cnt++;
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
      chk({vecs[i].name, "_illegal"}, 32'(out_illegal), 32'(vecs[i].exp_ill));
      chk({vecs[i].name, "_cnt"}, 32'(illegal_cnt), 32'(exp_cnt));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({vecs[i].name, "_drained"}, 32'(out_valid), 32'd0);
    end

    // ---------------- backpressure and ordering ----------------
    set_req(4'd1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);       // A: ADD
    in_valid = 1'b1;
    tick();
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_instr", out_instr, 32'h003100B3);
    chk("bp_ready_k1", 32'(in_ready), 32'd1);
    set_req(4'd1, 4'd1, 5'd5, 5'd6, 5'd7, 32'd0);       // B: SUB
    tick();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_a_hold1", out_instr, 32'h003100B3);
    set_req(4'd1, 4'd10, 5'd10, 5'd11, 5'd12, 32'd0);   // C: MUL
    tick();
    chk("bp_ready_full2", 32'(in_ready), 32'd0);
    chk("bp_a_hold2", out_instr, 32'h003100B3);
    chk("bp_valid_hold", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_instr", out_instr, 32'h407302B3);
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    tick();                                             // push C, pop B
    chk("bp_c_instr", out_instr, 32'h02C58533);
    chk("bp_k1_valid", 32'(out_valid), 32'd1);
    chk("bp_k1_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // ---------------- reset mid-operation ----------------
    set_req(4'd1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    in_valid = 1'b1;
    tick();
    set_req(4'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5);       // illegal second entry
    tick();
    in_valid = 1'b0;
    chk("mr_full", 32'(in_ready), 32'd0);
    chk("mr_cnt_before", 32'(illegal_cnt), 32'(exp_cnt + 1));
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_valid_async", 32'(out_valid), 32'd0);
    chk("mr_ready_async", 32'(in_ready), 32'd0);
    chk("mr_instr_async", out_instr, 32'd0);
    chk("mr_cnt_async", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mr_ready_rel", 32'(in_ready), 32'd1);
    guard = 0;
    repeat (3) begin
      if (out_valid) guard++;
      tick();
    end
    chk("mr_no_stale", 32'(guard), 32'd0);
    set_req(4'd0, 4'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mr_new_valid", 32'(out_valid), 32'd1);
    chk("mr_new_instr", out_instr, 32'hFFF00093);
    tick();

    // ---------------- counter saturation ----------------
    set_req(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b1;
    n_acc = 0;
    guard = 0;
    while (n_acc < 65535 && guard < 70000) begin
      if (in_ready) n_acc++;
      tick();
      guard++;
    end
    chk("sat_accepts_in_budget", 32'(n_acc), 32'd65535);
    chk("sat_cnt_ffff", 32'(illegal_cnt), 32'h0000FFFF);
    n_acc = 0;
    guard = 0;
    while (n_acc < 2 && guard < 10) begin
      if (in_ready) n_acc++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("sat_extra_accepts", 32'(n_acc), 32'd2);
    chk("sat_cnt_hold", 32'(illegal_cnt), 32'h0000FFFF);
    chk("sat_head_illegal", 32'(out_illegal), 32'd1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
